// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, valid/ready on both sides.
// Define SERIAL_ADD_OVF_EN to add the o_ovf two's-complement overflow output.

module full_half_add_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             o_carry,
  output logic             o_ovf
`else
  output logic             o_carry
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;

  assign w_accept = (r_state == S_IDLE) && i_valid;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);

  full_half_add_1bit u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_next = S_SHIFT;
      S_SHIFT: if (w_last)  w_next = S_DONE;
      S_DONE:  if (i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at r_sum[0].
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= i_cin;
      r_cnt   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
      r_carry <= w_fa_cout;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_msb_cin;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_msb_cin <= 1'b0;
    else if (w_last) r_msb_cin <= r_carry;
  end

  assign o_ovf = r_msb_cin ^ r_carry;
`endif

  assign o_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_DONE);
  assign o_sum   = r_sum;
  assign o_carry = r_carry;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: directed vectors plus a cycle-level reference model at WIDTH=8,
// and random operations on a second WIDTH=13 instance.

module tb_serial_adder_nbit;

  localparam int W  = 8;
  localparam int W2 = 13;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic          v8, rin8, cin8, ready8, valid8, carry8;
  logic [W-1:0]  a8, b8, sum8;
  logic          v13, rin13, cin13, ready13, valid13, carry13;
  logic [W2-1:0] a13, b13, sum13;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf8, ovf13;
`endif

  serial_adder_nbit #(.WIDTH(W)) u_dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (v8),
    .o_ready (ready8),
    .i_a     (a8),
    .i_b     (b8),
    .i_cin   (cin8),
    .o_valid (valid8),
    .i_ready (rin8),
    .o_sum   (sum8),
`ifdef SERIAL_ADD_OVF_EN
    .o_carry (carry8),
    .o_ovf   (ovf8)
`else
    .o_carry (carry8)
`endif
  );

  serial_adder_nbit #(.WIDTH(W2)) u_dut13 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (v13),
    .o_ready (ready13),
    .i_a     (a13),
    .i_b     (b13),
    .i_cin   (cin13),
    .o_valid (valid13),
    .i_ready (rin13),
    .o_sum   (sum13),
`ifdef SERIAL_ADD_OVF_EN
    .o_carry (carry13),
    .o_ovf   (ovf13)
`else
    .o_carry (carry13)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ovf_of(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  // Reference model: a transaction is accepted whenever idle and i_valid, the result
  // appears WIDTH edges later, and it stays until i_ready is seen.
  int           m_phase;
  int           m_left;
  logic [W-1:0] m_sum;
  logic         m_carry;
  logic         m_ovf;
  logic [W:0]   m_tot;

  assign m_tot = {1'b0, a8} + {1'b0, b8} + (W+1)'(cin8);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
    end else begin
      case (m_phase)
        0: if (v8) begin
             m_sum   <= m_tot[W-1:0];
             m_carry <= m_tot[W];
             m_ovf   <= ovf_of(a8[W-1], b8[W-1], m_tot[W-1]);
             m_left  <= W;
             m_phase <= 1;
           end
        1: begin
             m_left <= m_left - 1;
             if (m_left == 1) m_phase <= 2;
           end
        default: if (rin8) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready", 64'(ready8), 64'(1));
      check("rst_valid", 64'(valid8), 64'(0));
      check("rst_sum",   64'(sum8),   64'(0));
      check("rst_carry", 64'(carry8), 64'(0));
    end else begin
      check("model_ready", 64'(ready8), 64'(m_phase == 0));
      check("model_valid", 64'(valid8), 64'(m_phase == 2));
      if (m_phase == 2) begin
        check("model_sum",   64'(sum8),   64'(m_sum));
        check("model_carry", 64'(carry8), 64'(m_carry));
`ifdef SERIAL_ADD_OVF_EN
        check("model_ovf",   64'(ovf8),   64'(m_ovf));
`endif
      end
    end
  end

  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    check("accept_ready", 64'(ready8), 64'(1));
    a8 = a; b8 = b; cin8 = c; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  // Counts edges from the accept edge inclusive until o_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume;
    rin8 = 1'b1;
    @(posedge clk); #1;
    rin8 = 1'b0;
    check("idle_after_consume", 64'(ready8), 64'(1));
    check("valid_drop", 64'(valid8), 64'(0));
  endtask

  task automatic run_dir(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    do_accept(a, b, c);
    wait_valid(lat);
    check({name, "_latency"}, 64'(lat), 64'(W + 1));
    check({name, "_sum"},     64'(sum8),   64'(es));
    check({name, "_carry"},   64'(carry8), 64'(ec));
`ifdef SERIAL_ADD_OVF_EN
    check({name, "_ovf"},     64'(ovf8),   64'(eo));
`else
    if (eo === 1'bx) check({name, "_ovf"}, 64'(0), 64'(1));
`endif
    consume();
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    v8 = 1'b0; rin8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    v13 = 1'b0; rin13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 64'(ovf8), 64'(0));
`endif
    rst_n = 1'b1;

    run_dir("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_dir("wrap",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_dir("cin",   8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run_dir("msb",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Backpressure with a competing request that must be ignored.
    do_accept(8'h33, 8'h44, 1'b1);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'(W + 1));
    for (int i = 0; i < 5; i++) begin
      v8 = 1'b1; a8 = 8'h11; b8 = 8'h11; cin8 = 1'b0;
      @(posedge clk); #1;
      check("bp_valid", 64'(valid8), 64'(1));
      check("bp_sum",   64'(sum8),   64'(8'h78));
      check("bp_carry", 64'(carry8), 64'(0));
      check("bp_ready", 64'(ready8), 64'(0));
    end
    v8 = 1'b0;
    consume();
    @(posedge clk); #1;
    check("bp_no_capture", 64'(valid8), 64'(0));

    // Reset during SHIFT at bit 3.
    do_accept(8'hAA, 8'h55, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(ready8), 64'(1));
    check("mid_rst_valid", 64'(valid8), 64'(0));
    check("mid_rst_sum",   64'(sum8),   64'(0));
    check("mid_rst_carry", 64'(carry8), 64'(0));
`ifdef SERIAL_ADD_OVF_EN
    check("mid_rst_ovf",   64'(ovf8),   64'(0));
`endif
    @(negedge clk); #2;
    rst_n = 1'b1;
    run_dir("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [W-1:0] ra, rb;
          logic         rc;
          logic [W:0]   tot;
          ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
          tot = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
          do_accept(ra, rb, rc);
          wait_valid(lat);
          check("r8_latency", 64'(lat), 64'(W + 1));
          check("r8_result", 64'({carry8, sum8}), 64'(tot));
`ifdef SERIAL_ADD_OVF_EN
          check("r8_ovf", 64'(ovf8), 64'(ovf_of(ra[W-1], rb[W-1], tot[W-1])));
`endif
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          consume();
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [W2-1:0] ra, rb;
          logic          rc;
          logic [W2:0]   tot;
          int            l13;
          ra = W2'($urandom); rb = W2'($urandom); rc = 1'($urandom);
          tot = {1'b0, ra} + {1'b0, rb} + (W2+1)'(rc);
          check("r13_ready", 64'(ready13), 64'(1));
          a13 = ra; b13 = rb; cin13 = rc; v13 = 1'b1;
          @(posedge clk); #1;
          v13 = 1'b0;
          l13 = 1;
          while (!valid13 && l13 < 100) begin
            @(posedge clk); #1;
            l13++;
          end
          check("r13_latency", 64'(l13), 64'(W2 + 1));
          check("r13_result", 64'({carry13, sum13}), 64'(tot));
`ifdef SERIAL_ADD_OVF_EN
          check("r13_ovf", 64'(ovf13), 64'(ovf_of(ra[W2-1], rb[W2-1], tot[W2-1])));
`endif
          rin13 = 1'b1;
          @(posedge clk); #1;
          rin13 = 1'b0;
          check("r13_idle", 64'(ready13), 64'(1));
        end
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
